jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogador_automatico_pkg.sv | 31 +++
 rtl/jogador_automatico_rom.sv | 35 +++
 rtl/jogador_automatico.sv | 116 +++++++++++
 tb/tb_jogador_automatico.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: FSM state codes, timing
// defaults, index/button widths and small helper functions.
package jogador_automatico_pkg;

    localparam int IDX_W        = 4;   // play index width (16-entry table)
    localparam int BTN_W        = 4;   // one-hot button vector width
    localparam int HOLD_DEFAULT = 10;  // cycles a press is held
    localparam int GAP_DEFAULT  = 10;  // cycles of released buttons after a press

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        PRESSIONA = 4'd2,
        SOLTA     = 4'd3,
        PROXIMA   = 4'd4,
        FIM       = 4'd5
    } estado_t;

    // Timer counts 0..max(hold,gap)-1, so ceil(log2(max)) bits suffice.
    function automatic int timer_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Rotating a one-hot vector keeps it one-hot and always changes it.
    function automatic logic [BTN_W-1:0] rotl1(input logic [BTN_W-1:0] v);
        return {v[BTN_W-2:0], v[BTN_W-1]};
    endfunction

endpackage

// File: rtl/jogador_automatico_rom.sv
// Fixed 16x4 table of plays, one one-hot button pattern per index.
module rom_jogadas_16x4
    import jogador_automatico_pkg::*;
(
    input  logic [IDX_W-1:0] endereco,
    output logic [BTN_W-1:0] dado
);

    // Combinational table lookup
    always_comb begin
        // NOTE: assigning a default before the case guarantees every path
        // drives the output, so no latch can be inferred.
        dado = '0;
        case (endereco)
            4'd0:  dado = 4'b0001;
            4'd1:  dado = 4'b0010;
            4'd2:  dado = 4'b0100;
            4'd3:  dado = 4'b1000;
            4'd4:  dado = 4'b0100;
            4'd5:  dado = 4'b0010;
            4'd6:  dado = 4'b0001;
            4'd7:  dado = 4'b0001;
            4'd8:  dado = 4'b0010;
            4'd9:  dado = 4'b0010;
            4'd10: dado = 4'b0100;
            4'd11: dado = 4'b0100;
            4'd12: dado = 4'b1000;
            4'd13: dado = 4'b1000;
            4'd14: dado = 4'b0001;
            4'd15: dado = 4'b0100;
            default: dado = '0;
        endcase
    end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: replays plays 0..rodada from the table as timed button
// presses (HOLD cycles pressed, GAP cycles released, one cycle to advance),
// optionally corrupting the last play, and pulses pronto when done.
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT,
    parameter int GAP  = GAP_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [IDX_W-1:0] rodada,
    input  logic             errar,
    output logic [BTN_W-1:0] botoes,
    output logic             pronto,
    output logic [3:0]       db_estado
);

    localparam int TIMER_W = timer_width(HOLD, GAP);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP - 1);

    estado_t            estado;
    logic [IDX_W-1:0]   j;
    logic [TIMER_W-1:0] timer;
    logic [IDX_W-1:0]   rodada_l;
    logic               errar_l;
    logic [BTN_W-1:0]   jogada;

    rom_jogadas_16x4 u_rom (
        .endereco (j),
        .dado     (jogada)
    );

    // Round sequencer: state, play index, phase timer and latched round setup
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: every sequential register is updated with <= so all of them
        // see pre-edge values; reset clears all control state asynchronously.
        if (reset) begin
            estado   <= INICIAL;
            j        <= '0;
            timer    <= '0;
            rodada_l <= '0;
            errar_l  <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        rodada_l <= rodada;
                        errar_l  <= errar;
                        estado   <= PREPARA;
                    end
                end
                PREPARA: begin
                    j      <= '0;
                    timer  <= '0;
                    estado <= PRESSIONA;
                end
                PRESSIONA: begin
                    if (timer == HOLD_LAST) begin
                        timer  <= '0;
                        estado <= SOLTA;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                SOLTA: begin
                    if (timer == GAP_LAST) begin
                        timer  <= '0;
                        estado <= PROXIMA;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                PROXIMA: begin
                    // Compare before incrementing so j never wraps past 15.
                    if (j == rodada_l) begin
                        estado <= FIM;
                    end else begin
                        j      <= j + IDX_W'(1);
                        estado <= PRESSIONA;
                    end
                end
                FIM: begin
                    estado <= INICIAL;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Moore output decode from registered state and index
    always_comb begin
        botoes    = '0;
        pronto    = 1'b0;
        db_estado = estado;
        case (estado)
            PRESSIONA: begin
                if (errar_l && (j == rodada_l)) begin
                    botoes = rotl1(jogada);
                end else begin
                    botoes = jogada;
                end
            end
            FIM: begin
                pronto = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: a per-cycle expected-output
// scoreboard is filled when a round is started and drained as the DUT runs.
module tb_jogador_automatico;

    localparam int HOLD = 10;
    localparam int GAP  = 10;
    localparam int PLAY = HOLD + GAP + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] rodada;
    logic       errar;
    logic [3:0] botoes;
    logic       pronto;
    logic [3:0] db_estado;

    typedef struct packed {
        logic [3:0] botoes;
        logic       pronto;
        logic [3:0] estado;
    } saida_t;

    saida_t esperado[$];
    int     n_checks = 0;
    int     n_fails  = 0;

    logic [3:0] tabela [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b0001, 4'b0100};

    jogador_automatico #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .rodada    (rodada),
        .errar     (errar),
        .botoes    (botoes),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic saida_t mk(input logic [3:0] b, input logic p, input logic [3:0] s);
        saida_t x;
        x.botoes = b;
        x.pronto = p;
        x.estado = s;
        return x;
    endfunction

    // Expected outputs for every cycle after the sampling edge, ending with
    // one cycle back in INICIAL.
    task automatic push_round(input int r, input bit e);
        logic [3:0] p;
        esperado.push_back(mk(4'b0000, 1'b0, 4'd1));
        for (int k = 0; k <= r; k++) begin
            p = tabela[k];
            if (e && k == r) p = {p[2:0], p[3]};
            for (int h = 0; h < HOLD; h++) esperado.push_back(mk(p, 1'b0, 4'd2));
            for (int g = 0; g < GAP; g++) esperado.push_back(mk(4'b0000, 1'b0, 4'd3));
            esperado.push_back(mk(4'b0000, 1'b0, 4'd4));
        end
        esperado.push_back(mk(4'b0000, 1'b1, 4'd5));
        esperado.push_back(mk(4'b0000, 1'b0, 4'd0));
    endtask

    task automatic compare_next(input string tag);
        saida_t s;
        if (esperado.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            s = esperado.pop_front();
            check({tag, "_botoes"}, 32'(botoes), 32'(s.botoes));
            check({tag, "_pronto"}, 32'(pronto), 32'(s.pronto));
            check({tag, "_estado"}, 32'(db_estado), 32'(s.estado));
        end
    endtask

    // Starts a round (caller is #1 after an edge) and checks it cycle by cycle.
    task automatic run_round(input string name, input int r, input bit e,
                             input int hold_ini, input int flip_at, input int pulse_at);
        int cycle;
        int n_pronto;
        int pronto_cycle;
        rodada  = 4'(r);
        errar   = e;
        iniciar = 1'b1;
        push_round(r, e);
        @(posedge clock); #1;
        cycle = 1;
        n_pronto = 0;
        pronto_cycle = -1;
        while (esperado.size() > 0) begin
            if (cycle == pulse_at) iniciar = 1'b1;
            else if (cycle >= hold_ini) iniciar = 1'b0;
            if (cycle == flip_at) begin
                errar  = ~errar;
                rodada = ~rodada;
            end
            if (pronto === 1'b1) begin
                n_pronto++;
                pronto_cycle = cycle;
            end
            compare_next($sformatf("%s_c%0d", name, cycle));
            @(posedge clock); #1;
            cycle++;
        end
        iniciar = 1'b0;
        check({name, "_pronto_cycle"}, 32'(pronto_cycle), 32'(2 + (r + 1) * PLAY));
        check({name, "_pronto_count"}, 32'(n_pronto), 32'd1);
        // No restart: outputs stay idle for a few more cycles.
        for (int k = 0; k < 3; k++) begin
            esperado.push_back(mk(4'b0000, 1'b0, 4'd0));
            compare_next($sformatf("%s_idle%0d", name, k));
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        rodada  = 4'd0;
        errar   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        // Reset state
        esperado.push_back(mk(4'b0000, 1'b0, 4'd0));
        compare_next("reset");
        reset = 1'b0;
        // Stays in INICIAL without iniciar
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            esperado.push_back(mk(4'b0000, 1'b0, 4'd0));
            compare_next($sformatf("post_reset%0d", k));
        end

        run_round("r0", 0, 1'b0, 1, -1, -1);
        run_round("r3", 3, 1'b0, 1, -1, -1);
        run_round("r2_err", 2, 1'b1, 1, 30, -1);
        run_round("r1_hold5", 1, 1'b0, 5, -1, -1);
        run_round("r1_pulse_solta", 1, 1'b0, 1, -1, 15);

        // Reset in the middle of the third press (j=2)
        begin
            int cycle;
            rodada  = 4'd5;
            errar   = 1'b0;
            iniciar = 1'b1;
            push_round(5, 1'b0);
            @(posedge clock); #1;
            iniciar = 1'b0;
            cycle = 1;
            while (cycle <= 1 + 2 * PLAY + 4) begin
                compare_next($sformatf("rst_mid_c%0d", cycle));
                @(posedge clock); #1;
                cycle++;
            end
            check("rst_mid_pre_estado", 32'(db_estado), 32'd2);
            check("rst_mid_pre_botoes", 32'(botoes), 32'(tabela[2]));
            #2;
            reset = 1'b1;
            #1;
            check("rst_mid_botoes", 32'(botoes), 32'd0);
            check("rst_mid_estado", 32'(db_estado), 32'd0);
            check("rst_mid_pronto", 32'(pronto), 32'd0);
            esperado.delete();
            repeat (2) @(posedge clock);
            #1;
            reset = 1'b0;
            for (int k = 0; k < (2 + 4 * PLAY); k++) begin
                esperado.push_back(mk(4'b0000, 1'b0, 4'd0));
                compare_next($sformatf("rst_mid_after%0d", k));
                @(posedge clock); #1;
            end
        end

        run_round("r15", 15, 1'b0, 1, -1, -1);
        run_round("r15_err", 15, 1'b1, 1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
